// File: rtl/uart_rx_monitor_if.sv
`default_nettype none
// =============================================================================
// uart_rx_monitor_if : byte output handshake (out_data/out_valid/out_ready)
// Revision 1.0
// =============================================================================
interface uart_rx_monitor_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/uart_rx_monitor.sv
`default_nettype none
// =============================================================================
// uart_rx_monitor : 8N1 UART receiver with byte FIFO, framing/overflow/halt flags
// Revision 1.0
// =============================================================================
module uart_rx_monitor #(
  parameter int         CLKS_PER_BIT   = 868,
  parameter int         FIFO_DEPTH_LOG = 4,
  parameter logic [7:0] HALT_BYTE      = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  uart_rx_monitor_if.master out_if,
  output logic              frame_err,
  output logic              overflow,
  output logic              halt_seen,
  output logic [31:0]       byte_count
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int               DEPTH    = 1 << FIFO_DEPTH_LOG;
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // rx_prev only goes high once a genuine post-reset sample of rx_s was high,
  // so a line held low across reset release never looks like a start edge.
  logic rx_meta, rx_s, rx_prev, smp_v1, smp_v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      smp_v1  <= 1'b0;
      smp_v2  <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      smp_v1  <= 1'b1;
      smp_v2  <= smp_v1;
      rx_prev <= smp_v2 & rx_s;
    end
  end

  logic start_edge;
  assign start_edge = rx_prev & ~rx_s;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [7:0]       shreg, shreg_nx;
  logic             byte_ok, stop_bad;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    byte_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          cnt_nx   = HALF_BIT;
          state_nx = START;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
        end else if (!rx_s) begin
          cnt_nx     = FULL_BIT;
          bit_idx_nx = 3'd0;
          state_nx   = DATA;
        end else begin
          state_nx = IDLE;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
        end else begin
          shreg_nx   = {rx_s, shreg[7:1]};
          cnt_nx     = FULL_BIT;
          bit_idx_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
        end else begin
          byte_ok  = rx_s;
          stop_bad = ~rx_s;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic [7:0]              mem [DEPTH];
  logic [FIFO_DEPTH_LOG:0] wr_ptr, rd_ptr, wr_nx, rd_nx;
  logic                    fifo_full, pop, push, drop;
  logic [7:0]              head_nx;

  assign fifo_full = (wr_ptr[FIFO_DEPTH_LOG] != rd_ptr[FIFO_DEPTH_LOG]) &&
                     (wr_ptr[FIFO_DEPTH_LOG-1:0] == rd_ptr[FIFO_DEPTH_LOG-1:0]);
  assign pop  = out_if.out_valid & out_if.out_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
  assign push = byte_ok & (~fifo_full | pop);
  assign drop = byte_ok & fifo_full & ~pop;
  assign wr_nx = wr_ptr + {{FIFO_DEPTH_LOG{1'b0}}, push};
  assign rd_nx = rd_ptr + {{FIFO_DEPTH_LOG{1'b0}}, pop};
  assign head_nx = (rd_nx == wr_ptr) ? shreg : mem[rd_nx[FIFO_DEPTH_LOG-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_DEPTH_LOG-1:0]] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      bit_idx          <= '0;
      shreg            <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      out_if.out_data  <= 8'h00;
      out_if.out_valid <= 1'b0;
      frame_err        <= 1'b0;
      overflow         <= 1'b0;
      halt_seen        <= 1'b0;
      byte_count       <= '0;
    end else begin
      state            <= state_nx;
      cnt              <= cnt_nx;
      bit_idx          <= bit_idx_nx;
      shreg            <= shreg_nx;
      wr_ptr           <= wr_nx;
      rd_ptr           <= rd_nx;
      out_if.out_data  <= head_nx;
      out_if.out_valid <= (wr_nx != rd_nx);
      frame_err        <= stop_bad;
      if (drop) overflow <= 1'b1;
      if (byte_ok && (shreg == HALT_BYTE)) halt_seen <= 1'b1;
      if (byte_ok) byte_count <= byte_count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_monitor.sv
`default_nettype none
// =============================================================================
// tb_uart_rx_monitor : directed bench for uart_rx_monitor (8 clks/bit, 4-deep FIFO)
// Revision 1.0
// =============================================================================
module tb_uart_rx_monitor;
  localparam int CPB = 8;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        frame_err;
  logic        overflow;
  logic        halt_seen;
  logic [31:0] byte_count;

  uart_rx_monitor_if bus ();

  uart_rx_monitor #(
    .CLKS_PER_BIT  (CPB),
    .FIFO_DEPTH_LOG(2),
    .HALT_BYTE     (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .out_if    (bus),
    .frame_err (frame_err),
    .overflow  (overflow),
    .halt_seen (halt_seen),
    .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         valid_cycles = 0;
  int         fe_count = 0;
  logic [7:0] got[$];

  // Sample mid-low-phase, well clear of the rising edge and of input updates.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1) begin
      if (bus.out_valid === 1'b1) valid_cycles++;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got.push_back(bus.out_data);
      if (frame_err === 1'b1) fe_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    got.delete();
    valid_cycles = 0;
    fe_count     = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_log();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_v;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b1;
    rx            = 1'b1;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid",  {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data",   {24'd0, bus.out_data},  32'h00);
    check("rst_frame_err",  {31'd0, frame_err},     32'd0);
    check("rst_overflow",   {31'd0, overflow},      32'd0);
    check("rst_halt_seen",  {31'd0, halt_seen},     32'd0);
    check("rst_byte_count", byte_count,             32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_log();

    // 1: single byte, consumer always ready
    bus.out_ready = 1'b1;
    send_frame(8'h41, 1'b1);
    repeat (5) @(negedge clk);
    check("t1_pops",         got.size(),            32'd1);
    check("t1_data",         {24'd0, got[0]},       32'h41);
    check("t1_valid_cycles", valid_cycles,          32'd1);
    check("t1_byte_count",   byte_count,            32'd1);
    check("t1_frame_err",    fe_count,              32'd0);
    check("t1_overflow",     {31'd0, overflow},     32'd0);
    check("t1_halt_seen",    {31'd0, halt_seen},    32'd0);

    // 2: 2-cycle glitch is rejected as a false start
    apply_reset();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("t2_byte_count", byte_count,             32'd0);
    check("t2_frame_err",  fe_count,               32'd0);
    check("t2_out_valid",  {31'd0, bus.out_valid}, 32'd0);
    send_frame(8'h5A, 1'b1);
    repeat (5) @(negedge clk);
    check("t2_after_glitch_data", {24'd0, got[0]}, 32'h5A);

    // 3: bad stop bit
    apply_reset();
    send_frame(8'h55, 1'b0);
    repeat (5) @(negedge clk);
    check("t3_frame_err_pulses", fe_count,               32'd1);
    check("t3_byte_count",       byte_count,             32'd0);
    check("t3_out_valid",        {31'd0, bus.out_valid}, 32'd0);
    check("t3_pops",             got.size(),             32'd0);

    // 4: back-to-back bytes into a stalled 4-deep FIFO
    apply_reset();
    bus.out_ready = 1'b0;
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    repeat (5) @(negedge clk);
    check("t4_byte_count", byte_count,             32'd5);
    check("t4_overflow",   {31'd0, overflow},      32'd1);
    check("t4_out_valid",  {31'd0, bus.out_valid}, 32'd1);
    check("t4_head",       {24'd0, bus.out_data},  32'h01);
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_pops", got.size(), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t4_pop%0d", i), {24'd0, got[i]}, 32'(i + 1));
    check("t4_drained_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t4_overflow_sticky", {31'd0, overflow},    32'd1);

    // 5: halt byte is sticky
    apply_reset();
    bus.out_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    repeat (5) @(negedge clk);
    check("t5_halt_seen", {31'd0, halt_seen}, 32'd1);
    send_frame(8'h7A, 1'b1);
    repeat (5) @(negedge clk);
    check("t5_halt_sticky", {31'd0, halt_seen}, 32'd1);
    check("t5_byte_count",  byte_count,         32'd2);
    check("t5_last_data",   {24'd0, got[1]},    32'h7A);

    // 6: reset during data bit 4 (line low at release), then a clean frame
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i < 2) ? 1'b1 : 1'b0;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_async_byte_count", byte_count,             32'd0);
    check("t6_async_halt_seen",  {31'd0, halt_seen},     32'd0);
    check("t6_async_out_valid",  {31'd0, bus.out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check("t6_no_phantom_count", byte_count, 32'd0);
    check("t6_no_phantom_err",   fe_count,   32'd0);
    send_frame(8'hC3, 1'b1);
    repeat (5) @(negedge clk);
    check("t6_data",       {24'd0, got[0]}, 32'hC3);
    check("t6_byte_count", byte_count,      32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
